ks_multiword_add_seq: RTL and testbench

- Sequencer that sits directly in front of kogge_stone_top and also consumes its output.
- Accepts wide operands (NWORDS x DW bits), slices them into DW-bit words LSW-first, and drives each word pair plus the chained carry into the adder.
- Captures each sum/cout, rebuilds the wide result, and reports it with a one-cycle done pulse.
- Lets the 4-bit Kogge-Stone core perform 16-bit (default) multi-precision additions.

---
 rtl/ks_multiword_add_seq.sv | 140 ++++++++++++++
 tb/tb_ks_multiword_add_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ks_multiword_add_seq.sv
// ks_multiword_add_seq: multi-precision add sequencer for a DW-bit adder.
// It slices the wide operands into DW-bit words, least significant word first,
// and issues each word pair with the chained carry to an external adder. It
// collects each word's sum, rebuilds the wide result and pulses done once.
module ks_multiword_add_seq #(
  parameter int DW      = 4,
  parameter int NWORDS  = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DW*NWORDS-1:0]   op_a,
  input  logic [DW*NWORDS-1:0]   op_b,
  input  logic                   op_cin,
  output logic                   busy,
  output logic                   done,
  output logic [DW*NWORDS-1:0]   result,
  output logic                   result_cout,
  output logic [DW-1:0]          add_a,
  output logic [DW-1:0]          add_b,
  output logic                   add_cin,
  input  logic [DW-1:0]          add_sum,
  input  logic                   add_cout
);

  localparam int W  = DW * NWORDS;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [W-1:0]    op_a_q, op_b_q;
  logic [W-1:0]    words_q;
  logic [W-1:0]    result_q;
  logic            result_cout_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   add_a_q, add_b_q;
  logic            add_cin_q;
  logic            busy_q, done_q;

  logic            capture;
  logic            last_word;
  logic [IW-1:0]   idx_nxt;
  logic [W-1:0]    final_words;

  // Window/word bookkeeping and the full result as it will look after the final capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    final_words = words_q;
    final_words[(NWORDS-1)*DW +: DW] = add_sum;
    capture   = (cnt_q == CW'(ADD_LAT));
    last_word = (idx_q == IW'(NWORDS - 1));
    idx_nxt   = idx_q + 1'b1;
  end

  // Sequencer FSM: issue a word, wait out the adder latency, capture, chain the carry.
  // add_cin_q doubles as the chained carry register: it always holds the carry
  // belonging to the word currently in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the partial-sum word store is reset with everything else; it is a few
      // flops, not a RAM, and clearing it keeps an aborted run from leaking stale words.
      state_q       <= S_IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      words_q       <= '0;
      result_q      <= '0;
      result_cout_q <= 1'b0;
      idx_q         <= '0;
      cnt_q         <= '0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      add_cin_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_a_q    <= op_a;
            op_b_q    <= op_b;
            idx_q     <= '0;
            cnt_q     <= '0;
            add_a_q   <= op_a[DW-1:0];
            add_b_q   <= op_b[DW-1:0];
            add_cin_q <= op_cin;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!capture) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            words_q[idx_q*DW +: DW] <= add_sum;
            if (last_word) begin
              result_q      <= final_words;
              result_cout_q <= add_cout;
              done_q        <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              // Next word goes out on the same edge, so there is no dead cycle.
              idx_q     <= idx_nxt;
              add_a_q   <= op_a_q[idx_nxt*DW +: DW];
              add_b_q   <= op_b_q[idx_nxt*DW +: DW];
              add_cin_q <= add_cout;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign result_cout = result_cout_q;
  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign add_cin     = add_cin_q;

endmodule

// File: tb/tb_ks_multiword_add_seq.sv
// Bench for ks_multiword_add_seq with a registered 4-bit adder (ADD_LAT=1) in the loop.
module tb_ks_multiword_add_seq;

  localparam int DW = 4;
  localparam int NW = 4;
  localparam int W  = DW * NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  op_a, op_b;
  logic          op_cin;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          result_cout;
  logic [DW-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout;

  int errors = 0;
  int checks = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] last_res;
  logic         last_cout;

  ks_multiword_add_seq #(.DW(DW), .NWORDS(NW), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .busy(busy), .done(done), .result(result), .result_cout(result_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // One-cycle-latency adder standing in for the Kogge-Stone core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {add_cout, add_sum} <= '0;
    else      {add_cout, add_sum} <= add_a + add_b + add_cin;
  end

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    #2;
    if ({busy, done, result_cout, add_cin, result, add_a, add_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0",
               {busy, done, result_cout, add_cin, result, add_a, add_b});
    end
    checks++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    checks++;
    last_res = '0; last_cout = 1'b0;
  endtask

  // Issue one operation and follow it cycle by cycle. inject_n >= 0 raises a
  // stray start with other operands at that negedge; abort_n >= 0 pulls reset there.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int inject_n, input int abort_n, input string tag);
    logic [DW-1:0] exp_a[NW], exp_b[NW];
    logic          exp_cin[NW];
    logic [DW:0]   ws;
    logic          c;
    logic [W:0]    got, want;
    int            dones, k;
    c = cin;
    for (int i = 0; i < NW; i++) begin
      exp_a[i] = a[i*DW +: DW];
      exp_b[i] = b[i*DW +: DW];
      exp_cin[i] = c;
      ws = exp_a[i] + exp_b[i] + c;
      c = ws[DW];
    end
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; op_cin = cin;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
    @(posedge clk);
    dones = 0;
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == abort_n) begin
        rst = 1'b0;
        #1;
        if ({busy, done, result_cout, add_cin, result, add_a, add_b} !== '0) begin
          errors++;
          $display("FAIL %s abort_clear: got %h, want 0", tag,
                   {busy, done, result_cout, add_cin, result, add_a, add_b});
        end
        checks++;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s abort_quiet: busy=%b done=%b, want 0 0", tag, busy, done);
          end
          checks++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (result !== '0 || done !== 1'b0) begin
          errors++; $display("FAIL %s abort_after: result=%h done=%b, want 0 0", tag, result, done);
        end
        checks++;
        exp_q.delete();
        last_res = '0; last_cout = 1'b0;
        return;
      end
      if (busy !== (n <= 8)) begin
        errors++; $display("FAIL %s busy@%0d: got %b, want %b", tag, n, busy, (n <= 8));
      end
      checks++;
      if (done !== (n == 8)) begin
        errors++; $display("FAIL %s done@%0d: got %b, want %b", tag, n, done, (n == 8));
      end
      checks++;
      k = (n / 2 > NW - 1) ? NW - 1 : n / 2;
      if (add_a !== exp_a[k] || add_b !== exp_b[k] || add_cin !== exp_cin[k]) begin
        errors++;
        $display("FAIL %s issue@%0d: got a=%h b=%h cin=%b, want a=%h b=%h cin=%b",
                 tag, n, add_a, add_b, add_cin, exp_a[k], exp_b[k], exp_cin[k]);
      end
      checks++;
      if (n < 8) begin
        if (result !== last_res || result_cout !== last_cout) begin
          errors++;
          $display("FAIL %s result_hold@%0d: got %h/%b, want %h/%b",
                   tag, n, result, result_cout, last_res, last_cout);
        end
        checks++;
      end
      if (done === 1'b1) begin
        dones++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s scoreboard: done with no pending op", tag);
          checks++;
        end else begin
          want = exp_q.pop_front();
          got  = {result_cout, result};
          if (got !== want) begin
            errors++; $display("FAIL %s result: got %h, want %h", tag, got, want);
          end
          checks++;
          last_res = want[W-1:0]; last_cout = want[W];
        end
      end
      if (n == inject_n) begin
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555;
      end
    end
    if (dones != 1) begin
      errors++; $display("FAIL %s done_count: got %0d, want 1", tag, dones);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s pending: got %0d left, want 0", tag, exp_q.size());
      exp_q.delete();
    end
    checks++;
  endtask

  task automatic test_basic();
    run_op(16'h0001, 16'h0001, 1'b0, -1, -1, "one_plus_one");
    run_op(16'hFFFF, 16'h0001, 1'b0, -1, -1, "carry_ripple");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, -1, -1, "all_ones_cin");
  endtask

  task automatic test_start_while_busy();
    run_op(16'h1234, 16'h4321, 1'b1, 2, -1, "busy_start");
  endtask

  task automatic test_reset_abort();
    run_op(16'h1234, 16'h4321, 1'b1, -1, 4, "abort");
    run_op(16'h00FF, 16'h0001, 1'b0, -1, -1, "after_abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), -1, -1, "b2b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
